mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter: XLEN, default 32, datapath width; only 32 supported.
REQ-002 Parameter: RSP_TIMEOUT, default 255, max WAIT cycles before access fault; range 1..1023.
REQ-003 clk_i  in  1  sole clock; all state updates on rising edge.
REQ-004 rst_i  in  1  reset, synchronous, active-high.
REQ-005 flush_i  in  1  trap/redirect; discard in-flight op.
REQ-006 ex_valid_i  in  1  execute presents a memory op this cycle.
REQ-007 ex_rd_i / ex_wr_i  in  1 each  load / store; never both set.
REQ-008 ex_size_i  in  2  mem_size_e: byte=00, half=01, word=10.
REQ-009 ex_unsigned_i  in  1  zero-extend load (LBU/LHU).
REQ-010 ex_addr_i  in  XLEN  effective address (execute ALU result).
REQ-011 ex_wdata_i  in  XLEN  store data (execute forwarded rs2).
REQ-012 dmem_req_valid_o  out  1; dmem_req_ready_i  in  1; dmem_req_addr_o  out  XLEN, word-aligned; dmem_req_we_o  out  1; dmem_req_wstrb_o  out  4; dmem_req_wdata_o  out  XLEN.
REQ-013 dmem_rsp_valid_i  in  1; dmem_rsp_err_i  in  1; dmem_rsp_rdata_i  in  XLEN.
REQ-014 rd_data_o  out  XLEN  extended load data; rd_data_valid_o  out  1  one-cycle completion pulse.
REQ-015 stall_o  out  1  hold upstream pipeline.
REQ-016 exc_type_o  out  exc_type_e; exc_tval_o  out  XLEN  faulting address.

Function
REQ-017 States: IDLE, REQ, WAIT, DONE.
REQ-018 IDLE: ex_valid_i & (ex_rd_i|ex_wr_i) & aligned & !flush_i -> register addr/size/unsigned/we/wstrb/wdata, go REQ; stall_o=1 that cycle.
REQ-019 Misaligned: half with addr[0]=1 or word with addr[1:0]!=0 -> no bus request, stay IDLE, same-cycle exc_type_o=LOAD_MISALIGNED/STORE_MISALIGNED, exc_tval_o=ex_addr_i, stall_o=0.
REQ-020 REQ: dmem_req_valid_o=1, fields stable until dmem_req_ready_i; on handshake go WAIT, clear timeout counter.
REQ-021 WAIT: dmem_rsp_valid_i -> capture extended data and err, go DONE; else counter++; counter==RSP_TIMEOUT -> go DONE with err set.
REQ-022 DONE: stall_o=0; load without err -> rd_data_valid_o=1; err -> exc_type_o=LOAD_ACCESS_FAULT/STORE_ACCESS_FAULT, exc_tval_o=captured addr, rd_data_valid_o=0; next state IDLE.
REQ-023 stall_o=1 in REQ and WAIT, and in IDLE per REQ-018; 0 otherwise.
REQ-024 Min latency (ready=1, response next cycle): stall 3 cycles, completion on 4th.
REQ-025 wstrb: byte 0001<<addr[1:0]; half 0011<<{addr[1],0}; word 1111; wdata byte/half replicated across lanes; loads drive we=0, wstrb=0000.
REQ-026 Load data: rdata >> 8*addr[1:0], then sign- or zero-extend from bit 7/15; word unchanged.
REQ-027 flush_i in REQ: request kept until accepted (no bus retraction), drop flag set; in WAIT: drop flag set; dropped op in DONE -> no rd_data_valid_o, no exception.
REQ-028 flush_i asserted in DONE: completion outputs suppressed.
REQ-029 dmem_rsp_valid_i outside WAIT ignored (covers late response after timeout).
REQ-030 exc_type_o=NO_EXCEPTION, rd_data_valid_o=0 whenever not driven by REQ-019/022.

Reset
REQ-031 rst_i: state=IDLE, counter=0, drop flag=0, captured regs=0.
REQ-032 During/after reset: all outputs 0, exc_type_o=NO_EXCEPTION; reset mid-transaction abandons it without completion.

Structure
REQ-033 mem_size_e and exc_type_e additions (LOAD_MISALIGNED, STORE_MISALIGNED, LOAD_ACCESS_FAULT, STORE_ACCESS_FAULT) in ceres_param; state enum local.
REQ-034 Sub-module mem_align: combinational wstrb/wdata lane steering and load extraction/extension.

Verification
REQ-035 LB addr 0x1003, rdata 0x80FF_FF00, ready=1, rsp next cycle -> stall 3 cycles, rd_data_o=0xFFFF_FF80, rd_data_valid_o 1 pulse.
REQ-036 SH addr 0x2002, wdata 0x0000_1234 -> wstrb=1100, wdata=0x1234_1234, addr=0x2000, we=1.
REQ-037 LW addr 0x3001 -> no dmem_req_valid_o, exc LOAD_MISALIGNED, tval 0x3001, stall_o=0.
REQ-038 ready held 0 for 5 cycles then flush_i -> req fields stable until accept; response discarded, no valid, no exception.
REQ-039 RSP_TIMEOUT=4, no response -> LOAD_ACCESS_FAULT in DONE; late response afterwards ignored.
REQ-040 rst_i asserted while in WAIT -> IDLE next cycle, all outputs 0.

Source files
------------

// File: rtl/ceres_param.sv
// ---------------------------------------------------------------------------
// ceres_param
// Shared types for the load/store path.
//   mem_size_e   : access size as encoded by the decoder (byte/half/word)
//   exc_type_e   : exception cause reported by the memory stage
//   is_misaligned: natural-alignment check for a given size and addr[1:0]
// ---------------------------------------------------------------------------
package ceres_param;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'b00,
    MEM_HALF = 2'b01,
    MEM_WORD = 2'b10
  } mem_size_e;

  // NO_EXCEPTION is zero so an idle or reset stage drives all-zero outputs.
  // Fault codes follow the RISC-V mcause numbering.
  typedef enum logic [3:0] {
    NO_EXCEPTION       = 4'd0,
    LOAD_MISALIGNED    = 4'd4,
    LOAD_ACCESS_FAULT  = 4'd5,
    STORE_MISALIGNED   = 4'd6,
    STORE_ACCESS_FAULT = 4'd7
  } exc_type_e;

  localparam int unsigned CNT_W = 10;  // wide enough for RSP_TIMEOUT up to 1023

  // The reserved size encoding 2'b11 is checked like a word access.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      MEM_BYTE: is_misaligned = 1'b0;
      MEM_HALF: is_misaligned = addr_lo[0];
      default:  is_misaligned = (addr_lo != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/mem_align.sv
// ---------------------------------------------------------------------------
// mem_align
// Combinational byte-lane steering for the memory stage.
// Store side: st_size_i/st_addr_lo_i/st_data_i -> st_wstrb_o (lane enables)
//             and st_wdata_o (byte/half replicated into every lane).
// Load side : ld_size_i/ld_addr_lo_i/ld_unsigned_i/ld_rdata_i -> ld_data_o
//             (addressed lane shifted down, then sign/zero extended).
// ---------------------------------------------------------------------------
module mem_align
  import ceres_param::*;
(
  input  logic [1:0]  st_size_i,
  input  logic [1:0]  st_addr_lo_i,
  input  logic [31:0] st_data_i,
  output logic [3:0]  st_wstrb_o,
  output logic [31:0] st_wdata_o,
  input  logic [1:0]  ld_size_i,
  input  logic [1:0]  ld_addr_lo_i,
  input  logic        ld_unsigned_i,
  input  logic [31:0] ld_rdata_i,
  output logic [31:0] ld_data_o
);

  logic [31:0] ld_shifted;

  // Replicating the data means the memory only needs the strobe to pick
  // the lane; no per-lane muxing is required on the bus side.
  always_comb begin
    st_wstrb_o = 4'b1111;
    st_wdata_o = st_data_i;
    case (st_size_i)
      MEM_BYTE: begin
        st_wstrb_o = 4'b0001 << st_addr_lo_i;
        st_wdata_o = {4{st_data_i[7:0]}};
      end
      MEM_HALF: begin
        st_wstrb_o = 4'b0011 << {st_addr_lo_i[1], 1'b0};
        st_wdata_o = {2{st_data_i[15:0]}};
      end
      default: begin
        st_wstrb_o = 4'b1111;
        st_wdata_o = st_data_i;
      end
    endcase
  end

  assign ld_shifted = ld_rdata_i >> {ld_addr_lo_i, 3'b000};

  always_comb begin
    ld_data_o = ld_rdata_i;
    case (ld_size_i)
      MEM_BYTE: ld_data_o = ld_unsigned_i ? {24'd0, ld_shifted[7:0]}
                                          : {{24{ld_shifted[7]}}, ld_shifted[7:0]};
      MEM_HALF: ld_data_o = ld_unsigned_i ? {16'd0, ld_shifted[15:0]}
                                          : {{16{ld_shifted[15]}}, ld_shifted[15:0]};
      default:  ld_data_o = ld_rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage
// Pipeline memory stage: issues one load/store at a time on a valid/ready
// data-memory bus, waits for the response (bounded by RSP_TIMEOUT), and
// reports either extended load data or an exception.
//   clk_i, rst_i          : clock, synchronous active-high reset
//   flush_i               : discard the in-flight operation
//   ex_*                  : operation presented by execute
//   dmem_req_* / dmem_rsp_*: data-memory request / response channels
//   rd_data_o/_valid_o    : load result, one-cycle completion pulse
//   stall_o               : hold the upstream pipeline
//   exc_type_o/exc_tval_o : exception cause and faulting address
// XLEN must be 32.
// ---------------------------------------------------------------------------
module mem_stage
  import ceres_param::*;
#(
  parameter int XLEN        = 32,
  parameter int RSP_TIMEOUT = 255
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            ex_valid_i,
  input  logic            ex_rd_i,
  input  logic            ex_wr_i,
  input  logic [1:0]      ex_size_i,
  input  logic            ex_unsigned_i,
  input  logic [XLEN-1:0] ex_addr_i,
  input  logic [XLEN-1:0] ex_wdata_i,
  output logic            dmem_req_valid_o,
  input  logic            dmem_req_ready_i,
  output logic [XLEN-1:0] dmem_req_addr_o,
  output logic            dmem_req_we_o,
  output logic [3:0]      dmem_req_wstrb_o,
  output logic [XLEN-1:0] dmem_req_wdata_o,
  input  logic            dmem_rsp_valid_i,
  input  logic            dmem_rsp_err_i,
  input  logic [XLEN-1:0] dmem_rsp_rdata_i,
  output logic [XLEN-1:0] rd_data_o,
  output logic            rd_data_valid_o,
  output logic            stall_o,
  output exc_type_e       exc_type_o,
  output logic [XLEN-1:0] exc_tval_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] TIMEOUT = CNT_W'(RSP_TIMEOUT);

  state_e            state_q, state_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [1:0]        size_q, size_d;
  logic              unsigned_q, unsigned_d;
  logic              we_q, we_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              drop_q, drop_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [3:0]        st_wstrb;
  logic [31:0]       st_wdata;
  logic [31:0]       ld_data;
  logic              ex_op;
  logic              ex_misaligned;

  // Store steering works on the live execute operands (captured at accept);
  // load extraction works on the registered access against the live response.
  mem_align u_align (
    .st_size_i     (ex_size_i),
    .st_addr_lo_i  (ex_addr_i[1:0]),
    .st_data_i     (ex_wdata_i),
    .st_wstrb_o    (st_wstrb),
    .st_wdata_o    (st_wdata),
    .ld_size_i     (size_q),
    .ld_addr_lo_i  (addr_q[1:0]),
    .ld_unsigned_i (unsigned_q),
    .ld_rdata_i    (dmem_rsp_rdata_i),
    .ld_data_o     (ld_data)
  );

  assign ex_op         = ex_valid_i && (ex_rd_i || ex_wr_i) && !flush_i;
  assign ex_misaligned = is_misaligned(ex_size_i, ex_addr_i[1:0]);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      size_q     <= '0;
      unsigned_q <= 1'b0;
      we_q       <= 1'b0;
      wstrb_q    <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      drop_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      size_q     <= size_d;
      unsigned_q <= unsigned_d;
      we_q       <= we_d;
      wstrb_q    <= wstrb_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      drop_q     <= drop_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    addr_d           = addr_q;
    size_d           = size_q;
    unsigned_d       = unsigned_q;
    we_d             = we_q;
    wstrb_d          = wstrb_q;
    wdata_d          = wdata_q;
    rdata_d          = rdata_q;
    err_d            = err_q;
    drop_d           = drop_q;
    cnt_d            = cnt_q;

    dmem_req_valid_o = 1'b0;
    dmem_req_addr_o  = '0;
    dmem_req_we_o    = 1'b0;
    dmem_req_wstrb_o = '0;
    dmem_req_wdata_o = '0;
    rd_data_o        = '0;
    rd_data_valid_o  = 1'b0;
    stall_o          = 1'b0;
    exc_type_o       = NO_EXCEPTION;
    exc_tval_o       = '0;

    case (state_q)
      IDLE: begin
        if (ex_op) begin
          if (ex_misaligned) begin
            // Reported in the same cycle; the pipeline is not held.
            exc_type_o = ex_wr_i ? STORE_MISALIGNED : LOAD_MISALIGNED;
            exc_tval_o = ex_addr_i;
          end else begin
            stall_o    = 1'b1;
            addr_d     = ex_addr_i;
            size_d     = ex_size_i;
            unsigned_d = ex_unsigned_i;
            we_d       = ex_wr_i;
            wstrb_d    = ex_wr_i ? st_wstrb : 4'b0000;
            wdata_d    = ex_wr_i ? st_wdata : '0;
            rdata_d    = '0;
            err_d      = 1'b0;
            drop_d     = 1'b0;
            cnt_d      = '0;
            state_d    = REQ;
          end
        end
      end

      REQ: begin
        stall_o          = 1'b1;
        dmem_req_valid_o = 1'b1;
        dmem_req_addr_o  = {addr_q[XLEN-1:2], 2'b00};
        dmem_req_we_o    = we_q;
        dmem_req_wstrb_o = wstrb_q;
        dmem_req_wdata_o = wdata_q;
        // A request cannot be retracted once offered, so a flush only marks
        // the operation to be discarded when it completes.
        if (flush_i) begin
          drop_d = 1'b1;
        end
        if (dmem_req_ready_i) begin
          cnt_d   = '0;
          state_d = WAIT;
        end
      end

      WAIT: begin
        stall_o = 1'b1;
        if (flush_i) begin
          drop_d = 1'b1;
        end
        if (dmem_rsp_valid_i) begin
          rdata_d = we_q ? '0 : ld_data;
          err_d   = dmem_rsp_err_i;
          state_d = DONE;
        end else if (cnt_q + 1'b1 == TIMEOUT) begin
          // RSP_TIMEOUT cycles spent waiting without a response.
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
        if (!drop_q && !flush_i) begin
          if (err_q) begin
            exc_type_o = we_q ? STORE_ACCESS_FAULT : LOAD_ACCESS_FAULT;
            exc_tval_o = addr_q;
          end else if (!we_q) begin
            rd_data_valid_o = 1'b1;
            rd_data_o       = rdata_q;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
  import ceres_param::*;

  typedef struct {
    logic        dv;
    logic [31:0] data;
    logic [3:0]  exc;
    logic [31:0] tval;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic        ex_valid, ex_rd, ex_wr, ex_uns;
  logic [1:0]  ex_size;
  logic [31:0] ex_addr, ex_wdata;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] rd_data, exc_tval;
  logic        rd_valid, stall;
  exc_type_e   exc_type;

  int passed = 0;
  int total  = 0;
  int nfail  = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  mem_stage #(.XLEN(32), .RSP_TIMEOUT(4)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .flush_i          (flush),
    .ex_valid_i       (ex_valid),
    .ex_rd_i          (ex_rd),
    .ex_wr_i          (ex_wr),
    .ex_size_i        (ex_size),
    .ex_unsigned_i    (ex_uns),
    .ex_addr_i        (ex_addr),
    .ex_wdata_i       (ex_wdata),
    .dmem_req_valid_o (req_valid),
    .dmem_req_ready_i (req_ready),
    .dmem_req_addr_o  (req_addr),
    .dmem_req_we_o    (req_we),
    .dmem_req_wstrb_o (req_wstrb),
    .dmem_req_wdata_o (req_wdata),
    .dmem_rsp_valid_i (rsp_valid),
    .dmem_rsp_err_i   (rsp_err),
    .dmem_rsp_rdata_i (rsp_rdata),
    .rd_data_o        (rd_data),
    .rd_data_valid_o  (rd_valid),
    .stall_o          (stall),
    .exc_type_o       (exc_type),
    .exc_tval_o       (exc_tval)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      nfail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic push(input logic dv, input logic [31:0] data, input logic [3:0] exc,
                      input logic [31:0] tval);
    exp_t e;
    e.dv = dv; e.data = data; e.exc = exc; e.tval = tval;
    sb.push_back(e);
  endtask

  task automatic drive_ex(input logic rd, input logic wr, input logic [1:0] size,
                          input logic uns, input logic [31:0] addr, input logic [31:0] wd);
    ex_valid = 1'b1; ex_rd = rd; ex_wr = wr; ex_size = size;
    ex_uns = uns; ex_addr = addr; ex_wdata = wd;
  endtask

  task automatic clear_ex();
    ex_valid = 1'b0; ex_rd = 1'b0; ex_wr = 1'b0; ex_size = 2'b00;
    ex_uns = 1'b0; ex_addr = '0; ex_wdata = '0;
  endtask

  // Full transaction: ready in the REQ cycle, response in the first WAIT cycle.
  task automatic run_mem(input string tag, input logic rd, input logic wr,
                         input logic [1:0] size, input logic uns, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] rdata, input logic err,
                         input logic [3:0] exp_strb, input logic [31:0] exp_wd,
                         input logic flush_done);
    drive_ex(rd, wr, size, uns, addr, wd);
    mid();
    chk({tag, ".accept_stall"}, 32'(stall), 32'd1);
    chk({tag, ".accept_noreq"}, 32'(req_valid), 32'd0);
    nxt();
    clear_ex();
    req_ready = 1'b1;
    mid();
    chk({tag, ".req_valid"}, 32'(req_valid), 32'd1);
    chk({tag, ".req_stall"}, 32'(stall), 32'd1);
    chk({tag, ".req_addr"}, req_addr, {addr[31:2], 2'b00});
    chk({tag, ".req_we"}, 32'(req_we), 32'(wr));
    chk({tag, ".req_wstrb"}, 32'(req_wstrb), 32'(exp_strb));
    if (wr) chk({tag, ".req_wdata"}, req_wdata, exp_wd);
    nxt();
    req_ready = 1'b0;
    rsp_valid = 1'b1; rsp_rdata = rdata; rsp_err = err;
    mid();
    chk({tag, ".wait_stall"}, 32'(stall), 32'd1);
    nxt();
    rsp_valid = 1'b0; rsp_rdata = '0; rsp_err = 1'b0;
    flush = flush_done;
    mid();
    chk({tag, ".done_stall"}, 32'(stall), 32'd0);
    nxt();
    flush = 1'b0;
  endtask

  // Scoreboard: any completion pulse or exception must match the oldest
  // expectation; one with nothing expected is a failure.
  always @(negedge clk) begin
    if (!rst && (rd_valid || exc_type != NO_EXCEPTION)) begin
      if (sb.size() == 0) begin
        chk("sb.unexpected_output", {rd_valid, 27'd0, exc_type}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb.rd_valid", 32'(rd_valid), 32'(e.dv));
        chk("sb.exc_type", 32'(exc_type), 32'(e.exc));
        if (e.dv) chk("sb.rd_data", rd_data, e.data);
        else      chk("sb.exc_tval", exc_tval, e.tval);
        $display("txn out: valid=%0d data=0x%08h exc=%0d tval=0x%08h",
                 rd_valid, rd_data, exc_type, exc_tval);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int waitcnt;
    rst = 1'b1; flush = 1'b0; req_ready = 1'b0;
    rsp_valid = 1'b0; rsp_err = 1'b0; rsp_rdata = '0;
    clear_ex();

    // Reset state
    nxt();
    mid();
    chk("rst.req_valid", 32'(req_valid), 32'd0);
    chk("rst.stall", 32'(stall), 32'd0);
    chk("rst.rd_valid", 32'(rd_valid), 32'd0);
    chk("rst.exc_type", 32'(exc_type), 32'(NO_EXCEPTION));
    chk("rst.req_addr", req_addr, 32'd0);
    nxt();
    rst = 1'b0;
    nxt();
    $display("txn: reset done");

    // LB sign-extended, minimum latency
    push(1'b1, 32'hFFFF_FF80, NO_EXCEPTION, 32'h0);
    run_mem("lb", 1'b1, 1'b0, MEM_BYTE, 1'b0, 32'h0000_1003, 32'h0,
            32'h80FF_FF00, 1'b0, 4'b0000, 32'h0, 1'b0);
    mid();
    chk("lb.pulse_one_cycle", 32'(rd_valid), 32'd0);
    nxt();
    $display("txn: LB 0x1003");

    // SH lane steering
    run_mem("sh", 1'b0, 1'b1, MEM_HALF, 1'b0, 32'h0000_2002, 32'h0000_1234,
            32'h0, 1'b0, 4'b1100, 32'h1234_1234, 1'b0);
    $display("txn: SH 0x2002");

    // SB top lane
    run_mem("sb", 1'b0, 1'b1, MEM_BYTE, 1'b0, 32'h0000_7003, 32'h0000_00AB,
            32'h0, 1'b0, 4'b1000, 32'hABAB_ABAB, 1'b0);
    $display("txn: SB 0x7003");

    // LBU, LH signed, LW
    push(1'b1, 32'h0000_0080, NO_EXCEPTION, 32'h0);
    run_mem("lbu", 1'b1, 1'b0, MEM_BYTE, 1'b1, 32'h0000_6001, 32'h0,
            32'h1234_80AB, 1'b0, 4'b0000, 32'h0, 1'b0);
    $display("txn: LBU 0x6001");
    push(1'b1, 32'hFFFF_8001, NO_EXCEPTION, 32'h0);
    run_mem("lh", 1'b1, 1'b0, MEM_HALF, 1'b0, 32'h0000_6002, 32'h0,
            32'h8001_0000, 1'b0, 4'b0000, 32'h0, 1'b0);
    $display("txn: LH 0x6002");
    push(1'b1, 32'hDEAD_BEEF, NO_EXCEPTION, 32'h0);
    run_mem("lw", 1'b1, 1'b0, MEM_WORD, 1'b0, 32'h0000_6004, 32'h0,
            32'hDEAD_BEEF, 1'b0, 4'b0000, 32'h0, 1'b0);
    $display("txn: LW 0x6004");

    // Bus error responses
    push(1'b0, 32'h0, LOAD_ACCESS_FAULT, 32'h0000_6008);
    run_mem("lw_err", 1'b1, 1'b0, MEM_WORD, 1'b0, 32'h0000_6008, 32'h0,
            32'h5555_5555, 1'b1, 4'b0000, 32'h0, 1'b0);
    $display("txn: LW 0x6008 bus error");
    push(1'b0, 32'h0, STORE_ACCESS_FAULT, 32'h0000_700C);
    run_mem("sw_err", 1'b0, 1'b1, MEM_WORD, 1'b0, 32'h0000_700C, 32'hCAFE_F00D,
            32'h0, 1'b1, 4'b1111, 32'hCAFE_F00D, 1'b0);
    $display("txn: SW 0x700C bus error");

    // Misaligned load and store: no request, same-cycle exception
    push(1'b0, 32'h0, LOAD_MISALIGNED, 32'h0000_3001);
    drive_ex(1'b1, 1'b0, MEM_WORD, 1'b0, 32'h0000_3001, 32'h0);
    mid();
    chk("lw_mis.noreq", 32'(req_valid), 32'd0);
    chk("lw_mis.stall", 32'(stall), 32'd0);
    nxt();
    clear_ex();
    mid();
    chk("lw_mis.idle_noreq", 32'(req_valid), 32'd0);
    nxt();
    $display("txn: LW 0x3001 misaligned");
    push(1'b0, 32'h0, STORE_MISALIGNED, 32'h0000_7002);
    drive_ex(1'b0, 1'b1, MEM_WORD, 1'b0, 32'h0000_7002, 32'h1);
    mid();
    chk("sw_mis.noreq", 32'(req_valid), 32'd0);
    nxt();
    clear_ex();
    nxt();
    $display("txn: SW 0x7002 misaligned");

    // Back-pressure then flush: request held, result discarded
    drive_ex(1'b1, 1'b0, MEM_WORD, 1'b0, 32'h0000_4000, 32'h0);
    mid();
    nxt();
    clear_ex();
    for (int i = 0; i < 5; i++) begin
      mid();
      chk("bp.req_valid", 32'(req_valid), 32'd1);
      chk("bp.req_addr", req_addr, 32'h0000_4000);
      chk("bp.stall", 32'(stall), 32'd1);
      nxt();
    end
    flush = 1'b1;
    mid();
    chk("bp.flush_req_kept", 32'(req_valid), 32'd1);
    nxt();
    flush = 1'b0;
    req_ready = 1'b1;
    mid();
    chk("bp.req_after_flush", 32'(req_valid), 32'd1);
    nxt();
    req_ready = 1'b0;
    rsp_valid = 1'b1; rsp_rdata = 32'h1122_3344;
    mid();
    nxt();
    rsp_valid = 1'b0; rsp_rdata = '0;
    mid();
    chk("bp.done_stall", 32'(stall), 32'd0);
    chk("bp.done_novalid", 32'(rd_valid), 32'd0);
    chk("bp.done_noexc", 32'(exc_type), 32'(NO_EXCEPTION));
    nxt();
    $display("txn: LW 0x4000 backpressure+flush");

    // Response timeout, then a late response that must be ignored
    push(1'b0, 32'h0, LOAD_ACCESS_FAULT, 32'h0000_5002);
    drive_ex(1'b1, 1'b0, MEM_HALF, 1'b1, 32'h0000_5002, 32'h0);
    mid();
    nxt();
    clear_ex();
    req_ready = 1'b1;
    mid();
    chk("tmo.req_valid", 32'(req_valid), 32'd1);
    nxt();
    req_ready = 1'b0;
    waitcnt = 0;
    for (int i = 0; i < 20; i++) begin
      mid();
      if (!stall) break;
      waitcnt++;
      nxt();
    end
    chk("tmo.wait_cycles", 32'(waitcnt), 32'd4);
    nxt();
    rsp_valid = 1'b1; rsp_rdata = 32'h0000_FFFF;
    mid();
    chk("tmo.late_stall", 32'(stall), 32'd0);
    chk("tmo.late_noreq", 32'(req_valid), 32'd0);
    chk("tmo.late_novalid", 32'(rd_valid), 32'd0);
    nxt();
    rsp_valid = 1'b0; rsp_rdata = '0;
    nxt();
    $display("txn: LHU 0x5002 timeout");

    // Flush during DONE suppresses completion
    run_mem("flush_done", 1'b1, 1'b0, MEM_WORD, 1'b0, 32'h0000_8000, 32'h0,
            32'h7777_7777, 1'b0, 4'b0000, 32'h0, 1'b1);
    $display("txn: LW 0x8000 flush in DONE");

    // Reset while waiting for a response
    drive_ex(1'b1, 1'b0, MEM_WORD, 1'b0, 32'h0000_9000, 32'h0);
    mid();
    nxt();
    clear_ex();
    req_ready = 1'b1;
    mid();
    nxt();
    req_ready = 1'b0;
    rst = 1'b1;
    mid();
    nxt();
    mid();
    chk("rstw.req_valid", 32'(req_valid), 32'd0);
    chk("rstw.stall", 32'(stall), 32'd0);
    chk("rstw.rd_valid", 32'(rd_valid), 32'd0);
    chk("rstw.exc_type", 32'(exc_type), 32'(NO_EXCEPTION));
    chk("rstw.exc_tval", exc_tval, 32'd0);
    nxt();
    rst = 1'b0;
    rsp_valid = 1'b1; rsp_rdata = 32'h1234_5678;
    mid();
    chk("rstw.after_stall", 32'(stall), 32'd0);
    chk("rstw.after_novalid", 32'(rd_valid), 32'd0);
    nxt();
    rsp_valid = 1'b0; rsp_rdata = '0;
    nxt();
    nxt();
    $display("txn: LW 0x9000 reset in WAIT");

    chk("sb.drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
